// File: rtl/karatsuba_multiplier_if.sv
// Operand/result bundle for karatsuba_multiplier: the producer drives the operands,
// and the multiplier drives the combinational and registered products.
interface karatsuba_multiplier_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               in_valid;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_reg;
    logic               out_valid;

    modport master (
        output a,
        output b,
        output in_valid,
        input  product,
        input  product_reg,
        input  out_valid
    );

    modport slave (
        input  a,
        input  b,
        input  in_valid,
        output product,
        output product_reg,
        output out_valid
    );
endinterface

// File: rtl/karatsuba_multiplier.sv
// Exact unsigned WIDTH x WIDTH multiplier built from a recursive Karatsuba tree,
// with a one-cycle registered copy of the product and a matching valid flag.
module karatsuba_core #(
    parameter int N    = 16,
    parameter int LEAF = 4
) (
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [2*N-1:0] p
);
    generate
        if (N <= LEAF) begin : g_leaf
            assign p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        end else begin : g_split
            localparam int H = N / 2;

            logic [H-1:0]   a_hi;
            logic [H-1:0]   a_lo;
            logic [H-1:0]   b_hi;
            logic [H-1:0]   b_lo;
            logic [H:0]     sa;
            logic [H:0]     sb;
            logic [2*H-1:0] z2;
            logic [2*H-1:0] z0;
            logic [2*H-1:0] zl;
            logic [2*H+1:0] cross_a;
            logic [2*H+1:0] cross_b;
            logic [2*H+1:0] top_term;
            logic [2*H+1:0] zm;
            logic [2*H+1:0] z1;
            logic [2*N-1:0] z1_wide;

            assign a_hi = a[N-1:H];
            assign a_lo = a[H-1:0];
            assign b_hi = b[N-1:H];
            assign b_lo = b[H-1:0];
            assign sa   = {1'b0, a_hi} + {1'b0, a_lo};
            assign sb   = {1'b0, b_hi} + {1'b0, b_lo};

            karatsuba_core #(.N(H), .LEAF(LEAF)) u_high (
                .a (a_hi),
                .b (b_hi),
                .p (z2)
            );

            karatsuba_core #(.N(H), .LEAF(LEAF)) u_low (
                .a (a_lo),
                .b (b_lo),
                .p (z0)
            );

            // The (H+1)-bit middle operands are split into their carry bit and
            // H-bit body, so only the body-by-body product needs another
            // recursion level and the recursion always shrinks.
            karatsuba_core #(.N(H), .LEAF(LEAF)) u_mid (
                .a (sa[H-1:0]),
                .b (sb[H-1:0]),
                .p (zl)
            );

            always_comb begin
                cross_a  = sa[H] ? ({{(H+2){1'b0}}, sb[H-1:0]} << H) : '0;
                cross_b  = sb[H] ? ({{(H+2){1'b0}}, sa[H-1:0]} << H) : '0;
                top_term = {1'b0, sa[H] & sb[H], {(2*H){1'b0}}};
                zm       = {2'b00, zl} + cross_a + cross_b + top_term;
                z1       = zm - {2'b00, z2} - {2'b00, z0};
            end

            // z0 never reaches 2^(2H), so concatenating z2 above it is the
            // same as adding the two shifted partial products.
            always_comb begin
                z1_wide          = '0;
                z1_wide[2*H+1:0] = z1;
                p                = {z2, z0} + (z1_wide << H);
            end
        end
    endgenerate
endmodule

module karatsuba_multiplier #(
    parameter int WIDTH      = 16,
    parameter int LEAF_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    karatsuba_multiplier_if.slave bus
);
    logic [2*WIDTH-1:0] product_comb;

    karatsuba_core #(.N(WIDTH), .LEAF(LEAF_WIDTH)) u_core (
        .a (bus.a),
        .b (bus.b),
        .p (product_comb)
    );

    assign bus.product = product_comb;

    // The registered copy follows the combinational result every cycle; only
    // the valid flag carries the qualifier from in_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.product_reg <= '0;
            bus.out_valid   <= 1'b0;
        end else begin
            bus.product_reg <= product_comb;
            bus.out_valid   <= bus.in_valid;
        end
    end
endmodule

// File: tb/tb_karatsuba_multiplier.sv
// Self-checking bench for karatsuba_multiplier: directed table, random combinational
// and clocked sweeps against a plain-arithmetic model, and async reset sequences.
module tb_karatsuba_multiplier;
    localparam int WIDTH = 16;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [31:0]      expected;
    } vec_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    vec_t table_vecs[10];

    karatsuba_multiplier_if #(.WIDTH(WIDTH)) bus ();

    karatsuba_multiplier #(.WIDTH(WIDTH), .LEAF_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product from ordinary wide integer arithmetic.
    function automatic logic [31:0] model_product(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        longint unsigned full;
        full = longint'(x) * longint'(y);
        return full[31:0];
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if ($isunknown(actual) || actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic valid);
        bus.a        = x;
        bus.b        = y;
        bus.in_valid = valid;
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rv;
        logic [31:0]      exp_reg;

        vectors     = 0;
        miscompares = 0;

        table_vecs[0] = '{"zero_zero",  16'h0000, 16'h0000, 32'h0000_0000};
        table_vecs[1] = '{"zero_max",   16'h0000, 16'hFFFF, 32'h0000_0000};
        table_vecs[2] = '{"max_zero",   16'hFFFF, 16'h0000, 32'h0000_0000};
        table_vecs[3] = '{"max_max",    16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
        table_vecs[4] = '{"one_max",    16'h0001, 16'hFFFF, 32'h0000_FFFF};
        table_vecs[5] = '{"max_one",    16'hFFFF, 16'h0001, 32'h0000_FFFF};
        table_vecs[6] = '{"mid_8080",   16'h8080, 16'h8080, 32'h4080_4000};
        table_vecs[7] = '{"mid_00ff",   16'h00FF, 16'hFF00, 32'h00FE_0100};
        table_vecs[8] = '{"msb_msb",    16'h8000, 16'h8000, 32'h4000_0000};
        table_vecs[9] = '{"mixed",      16'h1234, 16'h5678, 32'h0626_0060};

        rst = 1'b1;
        apply_stimulus(16'd3, 16'd5, 1'b0);
        #1;
        check_output("reset_product_reg", bus.product_reg, 32'h0);
        check_output("reset_out_valid", {31'b0, bus.out_valid}, 32'h0);
        check_output("comb_during_reset", bus.product, 32'd15);

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(table_vecs[i].a, table_vecs[i].b, 1'b0);
            #5;
            check_output(table_vecs[i].name, bus.product, table_vecs[i].expected);
        end

        for (int i = 0; i < 1000; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            apply_stimulus(ra, rb, 1'b0);
            #5;
            check_output("rand_comb", bus.product, model_product(ra, rb));
        end

        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rv = ($urandom_range(0, 3) != 0);
            apply_stimulus(ra, rb, rv);
            exp_reg = model_product(ra, rb);
            @(posedge clk);
            #1;
            check_output("rand_reg", bus.product_reg, exp_reg);
            check_output("rand_valid", {31'b0, bus.out_valid}, {31'b0, rv});
            @(negedge clk);
        end

        apply_stimulus(16'hABCD, 16'h1357, 1'b1);
        @(posedge clk);
        #1;
        check_output("pre_reset_reg", bus.product_reg, model_product(16'hABCD, 16'h1357));
        check_output("pre_reset_valid", {31'b0, bus.out_valid}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check_output("async_reset_reg", bus.product_reg, 32'h0);
        check_output("async_reset_valid", {31'b0, bus.out_valid}, 32'h0);
        @(posedge clk);
        #1;
        check_output("held_reset_reg", bus.product_reg, 32'h0);
        check_output("held_reset_valid", {31'b0, bus.out_valid}, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(16'h0F0F, 16'hF0F0, 1'b0);
        @(posedge clk);
        #1;
        check_output("post_reset_reg_idle", bus.product_reg, model_product(16'h0F0F, 16'hF0F0));
        check_output("post_reset_valid_idle", {31'b0, bus.out_valid}, 32'h0);

        @(negedge clk);
        apply_stimulus(16'hFFFF, 16'hFFFF, 1'b1);
        #1;
        check_output("valid_before_edge", {31'b0, bus.out_valid}, 32'h0);
        @(posedge clk);
        #1;
        check_output("first_valid_reg", bus.product_reg, 32'hFFFE_0001);
        check_output("first_valid_flag", {31'b0, bus.out_valid}, 32'h1);

        @(negedge clk);
        apply_stimulus(16'h0000, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        check_output("valid_drop_reg", bus.product_reg, 32'h0);
        check_output("valid_drop_flag", {31'b0, bus.out_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
